// File: rtl/spram_fifo_nbank.sv
// Stream FIFO built from NUM_BANKS interleaved single-port RAM banks, with a
// 2-entry prefetch output stage, exact occupancy and almost-full/empty flags.
module spram_fifo_nbank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned AF_LEVEL   = DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2,
  parameter int unsigned CW         = $clog2(DEPTH + 2) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CW-1:0]         count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned BW   = $clog2(NUM_BANKS);
  localparam int unsigned RW   = AW - BW;
  localparam int unsigned ROWS = DEPTH / NUM_BANKS;
  localparam int unsigned RCW  = AW + 1;

  logic [AW-1:0]         waddr_q, waddr_d, raddr_q, raddr_d;
  logic [RCW-1:0]        ram_cnt_q, ram_cnt_d;
  logic                  inflight_q;
  logic [1:0]            out_cnt_q, out_cnt_d;
  logic [DATA_WIDTH-1:0] out0_q, out0_d, out1_q, out1_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  af_q, af_d, ae_q, ae_d, ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][ROWS];

  logic          pop, rd_issue, write_blocked, wr_en;
  logic [BW-1:0] wbank, rbank;
  logic [RW-1:0] wrow, rrow;

  assign wbank = waddr_q[BW-1:0];
  assign rbank = raddr_q[BW-1:0];
  assign wrow  = waddr_q[AW-1:BW];
  assign rrow  = raddr_q[AW-1:BW];

  assign m_valid = (out_cnt_q != 2'd0);
  assign pop     = m_valid && m_ready;

  // Prefetch counts a same-cycle pop as freed space so reads sustain full rate.
  assign rd_issue = (ram_cnt_q != '0) &&
                    (({1'b0, out_cnt_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);

  // Read wins a bank conflict; the write retries next cycle on a different read bank.
  assign write_blocked = rd_issue && (wbank == rbank);
  assign s_ready       = (ram_cnt_q < RCW'(DEPTH)) && !write_blocked;
  assign wr_en         = s_valid && s_ready;

  assign m_data       = out0_q;
  assign count        = count_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow_err = ovf_q;

  always_comb begin
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    out_cnt_d = out_cnt_q;
    out0_d    = out0_q;
    out1_d    = out1_q;

    if (wr_en)    waddr_d = waddr_q + AW'(1);
    if (rd_issue) raddr_d = raddr_q + AW'(1);

    ram_cnt_d = ram_cnt_q + RCW'(wr_en) - RCW'(rd_issue);

    // Output stage: head register drives m_data directly and holds when emptied.
    if (pop && inflight_q) begin
      if (out_cnt_q == 2'd2) begin
        out0_d = out1_q;
        out1_d = rd_data_q;
      end else begin
        out0_d = rd_data_q;
      end
    end else if (pop) begin
      if (out_cnt_q == 2'd2) out0_d = out1_q;
      out_cnt_d = out_cnt_q - 2'd1;
    end else if (inflight_q) begin
      if (out_cnt_q == 2'd0) out0_d = rd_data_q;
      else                   out1_d = rd_data_q;
      out_cnt_d = out_cnt_q + 2'd1;
    end

    count_d = count_q + CW'(wr_en) - CW'(pop);
    af_d    = (count_d >= CW'(AF_LEVEL));
    ae_d    = (count_d <= CW'(AE_LEVEL));
    ovf_d   = ovf_q || (s_valid && !s_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q    <= '0;
      raddr_q    <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      out_cnt_q  <= 2'd0;
      out0_q     <= '0;
      out1_q     <= '0;
      count_q    <= '0;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= rd_issue;
      out_cnt_q  <= out_cnt_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      count_q    <= count_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
    end
  end

  // Bank storage: contents survive reset; each bank sees at most one access per cycle.
  always_ff @(posedge clk) begin
    if (wr_en)    mem_q[wbank][wrow] <= s_data;
    if (rd_issue) rd_data_q          <= mem_q[rbank][rrow];
  end

endmodule

// File: tb/tb_spram_fifo_nbank.sv
// Randomized bench for spram_fifo_nbank: queue-based reference model checks
// ordering, occupancy, flags, output hold and reset behaviour.
module tb_spram_fifo_nbank;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned NB    = 4;
  localparam int unsigned AF    = DEPTH - 2;
  localparam int unsigned AE    = 2;
  localparam int unsigned CW    = $clog2(DEPTH + 2) + 1;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow_err;

  spram_fifo_nbank #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .NUM_BANKS  (NB),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue plus an occupancy counter.
  logic [DW-1:0] exp_q[$];
  int            mcount    = 0;
  int            n_pop     = 0;
  int            streak    = 0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mcount    = 0;
      streak    = 0;
      prev_hold = 1'b0;
    end else begin
      chk("count", 32'(count), 32'(mcount));
      chk("almost_full", 32'(almost_full), 32'(mcount >= int'(AF)));
      chk("almost_empty", 32'(almost_empty), 32'(mcount <= int'(AE)));
      if (prev_hold) chk("m_data_hold", 32'(m_data), 32'(prev_data));
      if (s_valid && !s_ready && mcount < int'(DEPTH)) begin
        streak++;
        chk("s_ready_stall_len", 32'(streak <= 1), 32'(1));
      end else begin
        streak = 0;
      end
      if (m_valid && m_ready) begin
        chk("pop_has_data", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
        n_pop++;
        mcount--;
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(s_data);
        mcount++;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  // Caller must be just after a rising edge.
  task automatic push(input logic [DW-1:0] d);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    chk("push_accept", 32'(ok), 32'(1));
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int t = 0; t < 300 && (exp_q.size() != 0 || count != '0); t++) @(negedge clk);
    chk("drain_model_empty", 32'(exp_q.size()), 32'(0));
    chk("drain_count", 32'(count), 32'(0));
    @(posedge clk);
    #1;
  endtask

  bit acc;
  int snap;

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // T1: reset state
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'(1));
    chk("rst_m_valid", 32'(m_valid), 32'(0));
    chk("rst_m_data", 32'(m_data), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_almost_empty", 32'(almost_empty), 32'(1));
    chk("rst_almost_full", 32'(almost_full), 32'(0));
    chk("rst_overflow", 32'(overflow_err), 32'(0));
    @(posedge clk);
    #1;

    // T2: single-word latency
    m_ready = 1'b1;
    push(8'hA5);
    chk("lat_edge_n", 32'(m_valid), 32'(0));
    @(posedge clk);
    #1 chk("lat_edge_n1", 32'(m_valid), 32'(0));
    @(posedge clk);
    #1 chk("lat_edge_n2", 32'(m_valid), 32'(1));
    chk("lat_data", 32'(m_data), 32'(8'hA5));
    repeat (2) @(posedge clk);
    #1 chk("lat_count_back", 32'(count), 32'(0));

    // T3: fill to DEPTH+2, overflow, ordered drain
    m_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 2; i++) push(DW'(i));
    @(negedge clk);
    chk("full_s_ready", 32'(s_ready), 32'(0));
    chk("full_count", 32'(count), 32'(DEPTH + 2));
    chk("full_almost_full", 32'(almost_full), 32'(1));
    chk("full_no_overflow_yet", 32'(overflow_err), 32'(0));
    @(posedge clk);
    #1 s_valid = 1'b1;
    s_data = 8'hFF;
    @(posedge clk);
    #1 s_valid = 1'b0;
    chk("overflow_sticky", 32'(overflow_err), 32'(1));
    snap = n_pop;
    drain();
    chk("fill_drain_words", 32'(n_pop - snap), 32'(DEPTH + 2));

    // T4: continuous streaming, random data
    s_valid = 1'b1;
    s_data  = DW'($urandom);
    m_ready = 1'b1;
    snap    = n_pop;
    repeat (400) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc) s_data = DW'($urandom);
    end
    drain();
    chk("stream_throughput", 32'((n_pop - snap) >= 380), 32'(1));

    // T5: random backpressure on both sides, several address wraps
    snap = n_pop;
    repeat (900) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc || !s_valid) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = DW'($urandom);
      end
      m_ready = ($urandom_range(0, 1) != 0);
    end
    drain();
    chk("wraps", 32'((n_pop - snap) >= 3 * int'(DEPTH)), 32'(1));

    // T6: reset mid-stream with 10 entries held
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(DW'(8'h50 + i));
    repeat (3) @(posedge clk);
    #1 chk("pre_rst_count", 32'(count), 32'(10));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'(0));
    chk("mid_rst_m_valid", 32'(m_valid), 32'(0));
    chk("mid_rst_overflow", 32'(overflow_err), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    push(8'h3C);
    for (int t = 0; t < 20 && !m_valid; t++) @(negedge clk);
    chk("post_rst_valid", 32'(m_valid), 32'(1));
    chk("post_rst_first", 32'(m_data), 32'(8'h3C));
    @(posedge clk);
    #1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
